// File: rtl/cur_blk_pingpong_pkg.sv
`default_nettype none
// ============================================================================
// Module : me_pkg
// Desc   : Shared sizing constants and read-FSM encoding for the current-block
//          ping-pong feeder of the motion-estimation SAD array.
// Rev    : 1.0  initial release
// ============================================================================
package me_pkg;

  localparam int BLK   = 8;             // block edge in pixels (power of two, 4..16)
  localparam int PIX_W = 8;             // bits per pixel
  localparam int ROW_W = BLK * PIX_W;   // one full block row
  localparam int IDX_W = $clog2(BLK);   // row / column index width

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK - 1);

  // Read-side FSM encoding
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_SEND = 1'b1;

endpackage : me_pkg
`default_nettype wire

// File: rtl/cur_blk_pingpong_if.sv
`default_nettype none
// ============================================================================
// Module : cur_blk_pingpong_if
// Desc   : Pixel input stream and block-row output stream of the feeder.
//          slave = the feeder itself, master = the environment driving it.
// Rev    : 1.0  initial release
// ============================================================================
interface cur_blk_pingpong_if;
  import me_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [PIX_W-1:0]     in_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic [ROW_W-1:0]     out_row;
  logic [IDX_W-1:0]     out_row_idx;
  logic                 out_last;
  logic                 blk_done;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, out_last, blk_done
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, out_last, blk_done
  );

endinterface : cur_blk_pingpong_if
`default_nettype wire

// File: rtl/cur_blk_pingpong_bank.sv
`default_nettype none
// ============================================================================
// Module : cur_blk_bank
// Desc   : One BLK x BLK pixel store. Single-pixel write port, full-row
//          asynchronous read port. Contents are not reset.
// Rev    : 1.0  initial release
// ============================================================================
module cur_blk_bank
  import me_pkg::*;
(
  input  wire logic             clock,
  input  wire logic             we,
  input  wire logic [IDX_W-1:0] wr_row,
  input  wire logic [IDX_W-1:0] wr_col,
  input  wire logic [PIX_W-1:0] wr_data,
  input  wire logic [IDX_W-1:0] rd_row,
  output logic      [ROW_W-1:0] rd_data
);

  logic [ROW_W-1:0] mem_q [BLK];

  // Pixel write: column c of a row lives in bits [c*PIX_W +: PIX_W]
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[wr_row][wr_col*PIX_W +: PIX_W] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_row];

endmodule : cur_blk_bank
`default_nettype wire

// File: rtl/cur_blk_pingpong.sv
`default_nettype none
// ============================================================================
// Module : cur_blk_pingpong
// Desc   : Assembles a raster pixel stream into BLK x BLK blocks in two
//          ping-pong banks and replays each full block one row per cycle.
// Rev    : 1.0  initial release
// ============================================================================
module cur_blk_pingpong
  import me_pkg::*;
(
  input  wire logic         clock,
  input  wire logic         rst,
  cur_blk_pingpong_if.slave bus
);

  logic [1:0]       full_q,      full_d;
  logic             wr_bank_q,   wr_bank_d;
  logic [IDX_W-1:0] wr_col_q,    wr_col_d;
  logic [IDX_W-1:0] wr_row_q,    wr_row_d;
  logic             rd_bank_q,   rd_bank_d;
  logic [IDX_W-1:0] rd_row_q,    rd_row_d;
  logic [0:0]       state_q,     state_d;
  logic             out_valid_q, out_valid_d;
  logic [ROW_W-1:0] out_row_q,   out_row_d;
  logic [IDX_W-1:0] out_idx_q,   out_idx_d;
  logic             out_last_q,  out_last_d;
  logic             blk_done_q,  blk_done_d;

  logic             w_wr_fire;
  logic             w_wr_done;
  logic             w_rd_fire;
  logic [IDX_W-1:0] w_rd_row_inc;
  logic [IDX_W-1:0] w_rd_addr;
  logic [ROW_W-1:0] w_bank_row [2];
  logic [ROW_W-1:0] w_rd_data;

  assign w_wr_fire    = bus.in_valid && !full_q[wr_bank_q];
  assign w_rd_fire    = out_valid_q && bus.out_ready;
  assign w_rd_row_inc = rd_row_q + 1'b1;
  // Look one row ahead on an accepted non-final row so rows stream without a bubble
  assign w_rd_addr    = (w_rd_fire && !out_last_q) ? w_rd_row_inc : rd_row_q;
  assign w_rd_data    = w_bank_row[rd_bank_q];

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      cur_blk_bank u_bank (
        .clock   (clock),
        .we      (w_wr_fire && (wr_bank_q == 1'(b))),
        .wr_row  (wr_row_q),
        .wr_col  (wr_col_q),
        .wr_data (bus.in_pixel),
        .rd_row  (w_rd_addr),
        .rd_data (w_bank_row[b])
      );
    end
  endgenerate

  // Write side: raster column/row counters, bank flip on the last pixel
  always_comb begin
    wr_col_d  = wr_col_q;
    wr_row_d  = wr_row_q;
    wr_bank_d = wr_bank_q;
    w_wr_done = 1'b0;
    if (w_wr_fire) begin
      if (wr_col_q == LAST_IDX) begin
        wr_col_d = '0;
        if (wr_row_q == LAST_IDX) begin
          wr_row_d  = '0;
          wr_bank_d = ~wr_bank_q;
          w_wr_done = 1'b1;
        end else begin
          wr_row_d = wr_row_q + 1'b1;
        end
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end
  end

  // Read FSM plus full flags; a completing write and a freeing read hit different banks
  always_comb begin
    full_d      = full_q;
    rd_bank_d   = rd_bank_q;
    rd_row_d    = rd_row_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    blk_done_d  = 1'b0;
    if (w_wr_done) begin
      full_d[wr_bank_q] = 1'b1;
    end
    case (state_q)
      RD_IDLE: begin
        rd_row_d = '0;
        if (full_q[rd_bank_q]) begin
          state_d = RD_SEND;
        end
      end
      default: begin
        if (!out_valid_q) begin
          // First row of a block: register it and raise valid
          out_valid_d = 1'b1;
          out_row_d   = w_rd_data;
          out_idx_d   = rd_row_q;
          out_last_d  = (rd_row_q == LAST_IDX);
        end else if (w_rd_fire) begin
          if (!out_last_q) begin
            rd_row_d   = w_rd_row_inc;
            out_row_d  = w_rd_data;
            out_idx_d  = w_rd_row_inc;
            out_last_d = (w_rd_row_inc == LAST_IDX);
          end else begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d   = ~rd_bank_q;
            rd_row_d    = '0;
            out_valid_d = 1'b0;
            blk_done_d  = 1'b1;
            // Includes a block completing this very cycle in the other bank
            state_d     = full_d[~rd_bank_q] ? RD_SEND : RD_IDLE;
          end
        end
      end
    endcase
  end

  // Control state and registered outputs; pixel storage is not reset
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_row_q    <= '0;
      state_q     <= RD_IDLE;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      blk_done_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_col_q    <= wr_col_d;
      wr_row_q    <= wr_row_d;
      rd_bank_q   <= rd_bank_d;
      rd_row_q    <= rd_row_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      blk_done_q  <= blk_done_d;
    end
  end

  assign bus.in_ready    = !full_q[wr_bank_q];
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_row_idx = out_idx_q;
  assign bus.out_last    = out_last_q;
  assign bus.blk_done    = blk_done_q;

endmodule : cur_blk_pingpong
`default_nettype wire

// File: tb/tb_cur_blk_pingpong.sv
`default_nettype none
// ============================================================================
// Module : tb_cur_blk_pingpong
// Desc   : Self-checking bench for the ping-pong block feeder. A negedge
//          monitor keeps a pixel-list model of stored blocks and checks every
//          emitted row, stall hold, blk_done and in_ready against it.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cur_blk_pingpong;
  import me_pkg::*;

  localparam int NPIX = BLK * BLK;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  cur_blk_pingpong_if bus ();

  cur_blk_pingpong dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int blocks_out = 0;
  int stall_cnt  = 0;

  // Model state
  logic [PIX_W-1:0] acc[$];
  logic [PIX_W-1:0] exp_px[$];
  logic [ROW_W-1:0] cap[$];
  int               mon_row = 0;
  bit               exp_done = 1'b0;
  bit               prev_stall = 1'b0;
  logic [ROW_W-1:0] prev_row;
  logic [IDX_W-1:0] prev_idx;
  logic             prev_last;

  // Monitor: everything sampled mid-cycle, away from the active edge
  always @(negedge clock) begin
    logic [ROW_W-1:0] exp_row;
    logic             exp_rdy;
    if (rst) begin
      acc.delete();
      exp_px.delete();
      mon_row    = 0;
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_row !== prev_row ||
            bus.out_row_idx !== prev_idx || bus.out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b idx=%0d row=%h, required valid=1 idx=%0d row=%h",
                   bus.out_valid, bus.out_row_idx, bus.out_row, prev_idx, prev_row);
        end
      end
      checks++;
      if (bus.blk_done !== exp_done) begin
        errors++;
        $display("FAIL blk_done: got %0b, required %0b", bus.blk_done, exp_done);
      end
      exp_done = 1'b0;
      exp_rdy = (exp_px.size() < 2 * NPIX);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready: got %0b, required %0b", bus.in_ready, exp_rdy);
      end
      if (bus.out_valid === 1'b1 && exp_px.size() < NPIX) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got out_valid=1, required 0 (no stored block)");
      end
      if (bus.in_valid && bus.in_ready) begin
        acc.push_back(bus.in_pixel);
        if (acc.size() == NPIX) begin
          foreach (acc[i]) exp_px.push_back(acc[i]);
          acc.delete();
        end
      end
      if (bus.out_valid && bus.out_ready && exp_px.size() >= NPIX) begin
        for (int c = 0; c < BLK; c++) exp_row[c*PIX_W +: PIX_W] = exp_px[mon_row*BLK + c];
        checks++;
        if (bus.out_row !== exp_row || bus.out_row_idx !== IDX_W'(mon_row) ||
            bus.out_last !== (mon_row == BLK - 1)) begin
          errors++;
          $display("FAIL row: idx=%0d last=%0b row=%h, required idx=%0d last=%0b row=%h",
                   bus.out_row_idx, bus.out_last, bus.out_row, mon_row, (mon_row == BLK - 1), exp_row);
        end
        cap.push_back(bus.out_row);
        if (mon_row == BLK - 1) begin
          repeat (NPIX) void'(exp_px.pop_front());
          mon_row  = 0;
          exp_done = 1'b1;
          blocks_out++;
        end else begin
          mon_row++;
        end
      end
      if (bus.out_valid && !bus.out_ready) stall_cnt++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_row   = bus.out_row;
      prev_idx   = bus.out_row_idx;
      prev_last  = bus.out_last;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_px(input logic [PIX_W-1:0] v, input int gap_pct);
    int  budget;
    bit  ok;
    while (int'($urandom_range(99)) < gap_pct) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_pixel = v;
    budget = 0;
    forever begin
      @(negedge clock);
      ok = bus.in_ready;
      tick();
      if (ok) break;
      budget++;
      if (budget > 3000) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: pixel not accepted, required acceptance within 3000 cycles");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_rand_block(input int gap_pct);
    for (int i = 0; i < NPIX; i++) drive_px(PIX_W'($urandom), gap_pct);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_px.size() != 0 || bus.out_valid) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: %0d pixels still pending, required 0", exp_px.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 6;
    if (bus.in_ready    !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b, required 1", bus.in_ready); end
    if (bus.out_valid   !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b, required 0", bus.out_valid); end
    if (bus.out_row     !== '0)   begin errors++; $display("FAIL rst_out_row: got %h, required 0", bus.out_row); end
    if (bus.out_row_idx !== '0)   begin errors++; $display("FAIL rst_row_idx: got %0d, required 0", bus.out_row_idx); end
    if (bus.out_last    !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b, required 0", bus.out_last); end
    if (bus.blk_done    !== 1'b0) begin errors++; $display("FAIL rst_blk_done: got %0b, required 0", bus.blk_done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int k;
    int n;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) drive_px(PIX_W'(i), 0);
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.out_valid && k < 10);
    checks++;
    if (k != 2) begin errors++; $display("FAIL latency: got %0d cycles, required 2", k); end
    n = 0;
    while (bus.out_valid && n < 20) begin
      if (n == 0) begin
        checks++;
        if (bus.out_row !== 64'h0706050403020100) begin
          errors++; $display("FAIL row0: got %h, required 0706050403020100", bus.out_row);
        end
      end
      if (n == 7) begin
        checks++;
        if (bus.out_row !== 64'h3f3e3d3c3b3a3938 || bus.out_last !== 1'b1) begin
          errors++; $display("FAIL row7: got %h last=%0b, required 3f3e3d3c3b3a3938 last=1", bus.out_row, bus.out_last);
        end
      end
      n++;
      tick();
    end
    checks++;
    if (n != BLK) begin errors++; $display("FAIL consecutive_rows: got %0d, required %0d", n, BLK); end
    checks++;
    if (bus.blk_done !== 1'b1) begin errors++; $display("FAIL basic_blk_done: got %0b, required 1", bus.blk_done); end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int start;
    start = blocks_out;
    bus.out_ready = 1'b0;
    drive_rand_block(0);
    drive_rand_block(0);
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL both_full_ready: got %0b, required 0", bus.in_ready); end
    fork
      drive_rand_block(0);
      begin
        repeat (10) tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL held_ready: got %0b, required 0", bus.in_ready); end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (blocks_out - start != 3) begin errors++; $display("FAIL b2b_blocks: got %0d, required 3", blocks_out - start); end
  endtask

  task automatic test_stall();
    int start;
    int target;
    int guard;
    start  = blocks_out;
    target = start + 2;
    stall_cnt = 0;
    fork
      begin
        drive_rand_block(20);
        drive_rand_block(20);
      end
      begin
        guard = 0;
        while (blocks_out < target && guard < 5000) begin
          bus.out_ready = 1'($urandom_range(1));
          tick();
          guard++;
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    checks++;
    if (blocks_out != target) begin errors++; $display("FAIL stall_blocks: got %0d, required %0d", blocks_out - start, 2); end
    checks++;
    if (stall_cnt == 0) begin errors++; $display("FAIL stall_seen: got 0 stalled cycles, required >0"); end
  endtask

  task automatic test_gaps();
    logic [ROW_W-1:0] ref_rows[$];
    bus.out_ready = 1'b1;
    cap.delete();
    for (int i = 0; i < NPIX; i++) drive_px(PIX_W'(i * 3 + 7), 0);
    wait_drain();
    ref_rows = cap;
    cap.delete();
    for (int i = 0; i < NPIX; i++) drive_px(PIX_W'(i * 3 + 7), 50);
    wait_drain();
    checks++;
    if (cap.size() != BLK || ref_rows.size() != BLK) begin
      errors++; $display("FAIL gap_rows: got %0d rows, required %0d", cap.size(), BLK);
    end else begin
      for (int r = 0; r < BLK; r++) begin
        checks++;
        if (cap[r] !== ref_rows[r]) begin
          errors++; $display("FAIL gap_row%0d: got %h, required %h", r, cap[r], ref_rows[r]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int start;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) drive_px(PIX_W'($urandom), 0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL async_rst: got valid=%0b ready=%0b, required valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %0b, required 0", bus.out_valid); end
    start = blocks_out;
    drive_rand_block(0);
    wait_drain();
    checks++;
    if (blocks_out - start != 1) begin errors++; $display("FAIL fresh_block: got %0d blocks, required 1", blocks_out - start); end
  endtask

  task automatic test_simultaneous();
    int start;
    int n;
    start = blocks_out;
    bus.out_ready = 1'b0;
    drive_rand_block(0);
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    for (int r = 0; r < BLK - 1; r++) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    checks++;
    if (bus.out_row_idx !== LAST_IDX || bus.out_last !== 1'b1) begin
      errors++; $display("FAIL sim_last_row: got idx=%0d last=%0b, required idx=%0d last=1", bus.out_row_idx, bus.out_last, BLK - 1);
    end
    for (int i = 0; i < NPIX - 1; i++) drive_px(PIX_W'($urandom), 0);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sim_pre_ready: got %0b, required 1", bus.in_ready); end
    bus.in_valid  = 1'b1;
    bus.in_pixel  = PIX_W'($urandom);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.blk_done !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL sim_gap: got valid=%0b done=%0b ready=%0b, required valid=0 done=1 ready=1",
               bus.out_valid, bus.blk_done, bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_row_idx !== '0) begin
      errors++; $display("FAIL sim_resume: got valid=%0b idx=%0d, required valid=1 idx=0", bus.out_valid, bus.out_row_idx);
    end
    wait_drain();
    checks++;
    if (blocks_out - start != 2) begin errors++; $display("FAIL sim_blocks: got %0d, required 2", blocks_out - start); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 ns, required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_cur_blk_pingpong
`default_nettype wire
